// File: rtl/rs_cdb_receiver_if.sv
// Bundle of the issue, broadcast-snoop and FU-dispatch signals of the
// reservation station. The master side drives instructions and broadcasts
// and accepts dispatches. The slave side is the reservation station itself.
interface rs_cdb_receiver_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        issue_op;
  logic [TAG_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vj;
  logic [TAG_W-1:0]  issue_qk;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_tag;

  logic              add_bc_valid;
  logic [TAG_W-1:0]  add_bc_tag;
  logic [DATA_W-1:0] add_bc_data;
  logic              mul_bc_valid;
  logic [TAG_W-1:0]  mul_bc_tag;
  logic [DATA_W-1:0] mul_bc_data;

  logic              fu_valid;
  logic              fu_ready;
  logic [1:0]        fu_op;
  logic [DATA_W-1:0] fu_vj;
  logic [DATA_W-1:0] fu_vk;
  logic [TAG_W-1:0]  fu_tag;

  logic [3:0]        occupancy;

  modport master (
    output issue_valid, issue_op, issue_qj, issue_vj, issue_qk, issue_vk,
    output add_bc_valid, add_bc_tag, add_bc_data,
    output mul_bc_valid, mul_bc_tag, mul_bc_data,
    output fu_ready,
    input  issue_ready, issue_tag, fu_valid, fu_op, fu_vj, fu_vk, fu_tag, occupancy
  );

  modport slave (
    input  issue_valid, issue_op, issue_qj, issue_vj, issue_qk, issue_vk,
    input  add_bc_valid, add_bc_tag, add_bc_data,
    input  mul_bc_valid, mul_bc_tag, mul_bc_data,
    input  fu_ready,
    output issue_ready, issue_tag, fu_valid, fu_op, fu_vj, fu_vk, fu_tag, occupancy
  );
endinterface

// File: rtl/rs_cdb_receiver.sv
// Reservation station at the receiving end of the common data bus.
// Entries wait for their operands, capture results from the add and mul
// broadcast buses (add bus wins when both match), and the lowest-index
// entry with both operands present is offered to the FU.
module rs_cdb_receiver #(
  parameter int DEPTH    = 3,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              reset,
  rs_cdb_receiver_if.slave  cdb_if
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry state
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [1:0]        op_q [DEPTH];
  logic [1:0]        op_d [DEPTH];
  logic [TAG_W-1:0]  qj_q [DEPTH];
  logic [TAG_W-1:0]  qj_d [DEPTH];
  logic [DATA_W-1:0] vj_q [DEPTH];
  logic [DATA_W-1:0] vj_d [DEPTH];
  logic [TAG_W-1:0]  qk_q [DEPTH];
  logic [TAG_W-1:0]  qk_d [DEPTH];
  logic [DATA_W-1:0] vk_q [DEPTH];
  logic [DATA_W-1:0] vk_d [DEPTH];
  logic [3:0]        occ_q, occ_d;

  logic [DEPTH-1:0]  ready_vec;
  logic [IDX_W-1:0]  free_idx;
  logic              any_free;
  logic [IDX_W-1:0]  ready_idx;
  logic              any_ready;
  logic              accept;
  logic              dispatch;

  // An entry is dispatchable only from registered state, so a wakeup is
  // always seen one cycle after the broadcast.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
    assign ready_vec[gi] = busy_q[gi] && (qj_q[gi] == '0) && (qk_q[gi] == '0);
  end

  // Replace a pending operand with broadcast data when its tag matches.
  // The add bus is checked first so that it wins over the mul bus.
  // A zero tag never matches because it means "value already present".
  function automatic logic [TAG_W+DATA_W-1:0] capture(
    input logic [TAG_W-1:0]  q,
    input logic [DATA_W-1:0] v
  );
    logic [TAG_W+DATA_W-1:0] r;
    r = {q, v};
    if (q != '0) begin
      if (cdb_if.add_bc_valid && (cdb_if.add_bc_tag == q))
        r = {{TAG_W{1'b0}}, cdb_if.add_bc_data};
      else if (cdb_if.mul_bc_valid && (cdb_if.mul_bc_tag == q))
        r = {{TAG_W{1'b0}}, cdb_if.mul_bc_data};
    end
    return r;
  endfunction

  // Lowest-index free entry and lowest-index ready entry.
  always_comb begin
    free_idx  = '0;
    any_free  = 1'b0;
    ready_idx = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
      if (ready_vec[i]) begin
        ready_idx = IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign accept   = cdb_if.issue_valid && any_free;
  assign dispatch = any_ready && cdb_if.fu_ready;

  assign cdb_if.issue_ready = any_free;
  assign cdb_if.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign cdb_if.fu_valid    = any_ready;
  assign cdb_if.fu_op       = op_q[ready_idx];
  assign cdb_if.fu_vj       = vj_q[ready_idx];
  assign cdb_if.fu_vk       = vk_q[ready_idx];
  assign cdb_if.fu_tag      = TAG_W'(TAG_BASE) + TAG_W'(ready_idx);
  assign cdb_if.occupancy   = occ_q;

  // Next entry state: snoop busy entries, retire the dispatched entry and
  // write the accepted instruction (with same-cycle broadcast bypass).
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    qj_d   = qj_q;
    vj_d   = vj_q;
    qk_d   = qk_q;
    vk_d   = vk_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        {qj_d[i], vj_d[i]} = capture(qj_q[i], vj_q[i]);
        {qk_d[i], vk_d[i]} = capture(qk_q[i], vk_q[i]);
        if (dispatch && (ready_idx == IDX_W'(i)))
          busy_d[i] = 1'b0;
      end else if (accept && (free_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = cdb_if.issue_op;
        {qj_d[i], vj_d[i]} = capture(cdb_if.issue_qj, cdb_if.issue_vj);
        {qk_d[i], vk_d[i]} = capture(cdb_if.issue_qk, cdb_if.issue_vk);
      end
    end
    occ_d = occ_q + {3'b000, accept} - {3'b000, dispatch};
  end

  // Register update; reset drops every entry but leaves payload untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      occ_q  <= '0;
    end else begin
      busy_q <= busy_d;
      occ_q  <= occ_d;
      op_q   <= op_d;
      qj_q   <= qj_d;
      vj_q   <= vj_d;
      qk_q   <= qk_d;
      vk_q   <= vk_d;
    end
  end

endmodule

// File: tb/tb_rs_cdb_receiver.sv
// Self-checking bench for rs_cdb_receiver: directed scenarios plus a
// randomized run compared against a behavioural model of the station.
module tb_rs_cdb_receiver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  rs_cdb_receiver_if #(.TAG_W(4), .DATA_W(32)) bus ();

  rs_cdb_receiver #(.DEPTH(3), .TAG_W(4), .DATA_W(32), .TAG_BASE(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .cdb_if (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: a table of instructions waiting for operands.
  bit          m_busy [3];
  logic [1:0]  m_op   [3];
  logic [3:0]  m_qj   [3];
  logic [3:0]  m_qk   [3];
  logic [31:0] m_vj   [3];
  logic [31:0] m_vk   [3];
  int          m_occ;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_op     = 2'd0;
    bus.issue_qj     = 4'd0;
    bus.issue_vj     = 32'd0;
    bus.issue_qk     = 4'd0;
    bus.issue_vk     = 32'd0;
    bus.add_bc_valid = 1'b0;
    bus.add_bc_tag   = 4'd0;
    bus.add_bc_data  = 32'd0;
    bus.mul_bc_valid = 1'b0;
    bus.mul_bc_tag   = 4'd0;
    bus.mul_bc_data  = 32'd0;
    bus.fu_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] qj, input logic [31:0] vj,
                       input logic [3:0] qk, input logic [31:0] vk);
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_qj = qj;
    bus.issue_vj = vj;
    bus.issue_qk = qk;
    bus.issue_vk = vk;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%0b exp=1", bus.issue_ready); end
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL reset_fu_valid got=%0b exp=0", bus.fu_valid); end
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.issue_tag !== 4'd1) begin failures++; $display("FAIL reset_issue_tag got=%0d exp=1", bus.issue_tag); end
    $display("test_reset done");
  endtask

  task automatic test_basic_dispatch();
    do_reset();
    issue(2'd1, 4'd0, 32'd5, 4'd0, 32'd7);
    bus.fu_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.issue_tag !== 4'd1) begin failures++; $display("FAIL basic_issue_tag got=%0d exp=1", bus.issue_tag); end
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", bus.fu_valid); end
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b1) begin failures++; $display("FAIL basic_fu_valid got=%0b exp=1", bus.fu_valid); end
    checks++; if (bus.fu_tag !== 4'd1) begin failures++; $display("FAIL basic_fu_tag got=%0d exp=1", bus.fu_tag); end
    checks++; if (bus.fu_op !== 2'd1) begin failures++; $display("FAIL basic_fu_op got=%0d exp=1", bus.fu_op); end
    checks++; if (bus.fu_vj !== 32'd5) begin failures++; $display("FAIL basic_fu_vj got=%0d exp=5", bus.fu_vj); end
    checks++; if (bus.fu_vk !== 32'd7) begin failures++; $display("FAIL basic_fu_vk got=%0d exp=7", bus.fu_vk); end
    checks++; if (bus.occupancy !== 4'd1) begin failures++; $display("FAIL basic_occ1 got=%0d exp=1", bus.occupancy); end
    tick();
    @(negedge clk);
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("FAIL basic_occ0 got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%0b exp=0", bus.fu_valid); end
    $display("test_basic_dispatch done");
  endtask

  task automatic test_wakeup();
    do_reset();
    bus.fu_ready = 1'b1;
    issue(2'd2, 4'd4, 32'd0, 4'd0, 32'd3);
    tick();
    bus.issue_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL wake_wait%0d got=%0b exp=0", c, bus.fu_valid); end
      tick();
    end
    bus.add_bc_valid = 1'b1;
    bus.add_bc_tag = 4'd4;
    bus.add_bc_data = 32'h99;
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL wake_same_cycle got=%0b exp=0", bus.fu_valid); end
    tick();
    bus.add_bc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b1) begin failures++; $display("FAIL wake_valid got=%0b exp=1", bus.fu_valid); end
    checks++; if (bus.fu_vj !== 32'h99) begin failures++; $display("FAIL wake_vj got=%0h exp=99", bus.fu_vj); end
    checks++; if (bus.fu_vk !== 32'd3) begin failures++; $display("FAIL wake_vk got=%0h exp=3", bus.fu_vk); end
    tick();
    @(negedge clk);
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("FAIL wake_occ got=%0d exp=0", bus.occupancy); end
    $display("test_wakeup done");
  endtask

  task automatic test_bypass();
    do_reset();
    bus.fu_ready = 1'b1;
    issue(2'd3, 4'd5, 32'hDEAD, 4'd6, 32'hBEEF);
    bus.add_bc_valid = 1'b1; bus.add_bc_tag = 4'd5; bus.add_bc_data = 32'd1;
    bus.mul_bc_valid = 1'b1; bus.mul_bc_tag = 4'd6; bus.mul_bc_data = 32'd2;
    tick();
    idle_inputs();
    bus.fu_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%0b exp=1", bus.fu_valid); end
    checks++; if (bus.fu_vj !== 32'd1) begin failures++; $display("FAIL bypass_vj got=%0h exp=1", bus.fu_vj); end
    checks++; if (bus.fu_vk !== 32'd2) begin failures++; $display("FAIL bypass_vk got=%0h exp=2", bus.fu_vk); end
    tick();
    $display("test_bypass done");
  endtask

  task automatic test_full_and_switch();
    do_reset();
    for (int e = 0; e < 3; e++) begin
      issue(2'(e), 4'(8 + e), 32'd0, 4'd0, 32'(e));
      @(negedge clk);
      checks++; if (bus.issue_tag !== 4'(e + 1)) begin failures++; $display("FAIL full_tag%0d got=%0d exp=%0d", e, bus.issue_tag, e + 1); end
      tick();
    end
    issue(2'd0, 4'd0, 32'h44, 4'd0, 32'h44);
    @(negedge clk);
    checks++; if (bus.issue_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.issue_ready); end
    checks++; if (bus.occupancy !== 4'd3) begin failures++; $display("FAIL full_occ got=%0d exp=3", bus.occupancy); end
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.occupancy !== 4'd3) begin failures++; $display("FAIL full_ignored_occ got=%0d exp=3", bus.occupancy); end
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL full_ignored_valid got=%0b exp=0", bus.fu_valid); end
    bus.add_bc_valid = 1'b1; bus.add_bc_tag = 4'd10; bus.add_bc_data = 32'h22;
    tick();
    bus.add_bc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_tag !== 4'd3 || bus.fu_valid !== 1'b1) begin failures++; $display("FAIL switch_first got=%0d/%0b exp=3/1", bus.fu_tag, bus.fu_valid); end
    checks++; if (bus.fu_vj !== 32'h22) begin failures++; $display("FAIL switch_first_vj got=%0h exp=22", bus.fu_vj); end
    bus.mul_bc_valid = 1'b1; bus.mul_bc_tag = 4'd8; bus.mul_bc_data = 32'h11;
    tick();
    bus.mul_bc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_tag !== 4'd1) begin failures++; $display("FAIL switch_lower got=%0d exp=1", bus.fu_tag); end
    checks++; if (bus.fu_vj !== 32'h11) begin failures++; $display("FAIL switch_lower_vj got=%0h exp=11", bus.fu_vj); end
    bus.fu_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (bus.fu_tag !== 4'd3 || bus.fu_valid !== 1'b1) begin failures++; $display("FAIL drain_second got=%0d/%0b exp=3/1", bus.fu_tag, bus.fu_valid); end
    checks++; if (bus.occupancy !== 4'd2) begin failures++; $display("FAIL drain_occ2 got=%0d exp=2", bus.occupancy); end
    tick();
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", bus.fu_valid); end
    checks++; if (bus.occupancy !== 4'd1) begin failures++; $display("FAIL drain_occ1 got=%0d exp=1", bus.occupancy); end
    $display("test_full_and_switch done");
  endtask

  task automatic test_bus_priority();
    do_reset();
    issue(2'd0, 4'd4, 32'd0, 4'd0, 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    bus.add_bc_valid = 1'b1; bus.add_bc_tag = 4'd4; bus.add_bc_data = 32'hA;
    bus.mul_bc_valid = 1'b1; bus.mul_bc_tag = 4'd4; bus.mul_bc_data = 32'hB;
    tick();
    bus.add_bc_valid = 1'b0;
    bus.mul_bc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_vj !== 32'hA) begin failures++; $display("FAIL priority_vj got=%0h exp=a", bus.fu_vj); end
    $display("test_bus_priority done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(2'd0, 4'd0, 32'd1, 4'd0, 32'd1);
    tick();
    issue(2'd0, 4'd11, 32'd0, 4'd0, 32'd2);
    tick();
    bus.issue_valid = 1'b0;
    bus.fu_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", bus.fu_valid); end
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", bus.issue_ready); end
    bus.add_bc_valid = 1'b1; bus.add_bc_tag = 4'd11; bus.add_bc_data = 32'h5;
    tick();
    bus.add_bc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.fu_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale got=%0b exp=0", bus.fu_valid); end
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("FAIL rstmid_stale_occ got=%0d exp=0", bus.occupancy); end
    $display("test_reset_mid done");
  endtask

  // Model: an operand waiting on tag q picks up the add-bus value first,
  // otherwise the mul-bus value, when the tag is broadcast.
  function automatic void model_capture(input logic [3:0] q, input logic [31:0] v,
                                        output logic [3:0] qo, output logic [31:0] vo);
    qo = q;
    vo = v;
    if (q != 0 && bus.add_bc_valid && bus.add_bc_tag == q) begin qo = 0; vo = bus.add_bc_data; end
    else if (q != 0 && bus.mul_bc_valid && bus.mul_bc_tag == q) begin qo = 0; vo = bus.mul_bc_data; end
  endfunction

  task automatic test_random();
    int fi, ri, n_disp;
    bit acc, disp;
    do_reset();
    for (int e = 0; e < 3; e++) m_busy[e] = 0;
    m_occ = 0;
    n_disp = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.issue_valid  = ($urandom_range(0, 99) < 50);
      bus.issue_op     = 2'($urandom);
      bus.issue_qj     = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      bus.issue_vj     = $urandom;
      bus.issue_qk     = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      bus.issue_vk     = $urandom;
      bus.add_bc_valid = ($urandom_range(0, 99) < 40);
      bus.add_bc_tag   = 4'($urandom_range(0, 6));
      bus.add_bc_data  = $urandom;
      bus.mul_bc_valid = ($urandom_range(0, 99) < 40);
      bus.mul_bc_tag   = 4'($urandom_range(0, 6));
      bus.mul_bc_data  = $urandom;
      bus.fu_ready     = ($urandom_range(0, 99) < 45);
      fi = -1;
      ri = -1;
      for (int e = 2; e >= 0; e--) begin
        if (!m_busy[e]) fi = e;
        if (m_busy[e] && m_qj[e] == 0 && m_qk[e] == 0) ri = e;
      end
      @(negedge clk);
      checks++; if (bus.issue_ready !== (fi >= 0)) begin failures++; $display("FAIL rnd_issue_ready cyc=%0d got=%0b exp=%0b", cyc, bus.issue_ready, fi >= 0); end
      if (fi >= 0) begin
        checks++; if (bus.issue_tag !== 4'(fi + 1)) begin failures++; $display("FAIL rnd_issue_tag cyc=%0d got=%0d exp=%0d", cyc, bus.issue_tag, fi + 1); end
      end
      checks++; if (bus.fu_valid !== (ri >= 0)) begin failures++; $display("FAIL rnd_fu_valid cyc=%0d got=%0b exp=%0b", cyc, bus.fu_valid, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (bus.fu_tag !== 4'(ri + 1) || bus.fu_op !== m_op[ri] || bus.fu_vj !== m_vj[ri] || bus.fu_vk !== m_vk[ri]) begin
          failures++;
          $display("FAIL rnd_fu_payload cyc=%0d got=t%0d op%0d %0h %0h exp=t%0d op%0d %0h %0h", cyc,
                   bus.fu_tag, bus.fu_op, bus.fu_vj, bus.fu_vk, ri + 1, m_op[ri], m_vj[ri], m_vk[ri]);
        end
      end
      checks++; if (bus.occupancy !== 4'(m_occ)) begin failures++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", cyc, bus.occupancy, m_occ); end
      // Advance the model by one clock edge.
      acc  = bus.issue_valid && (fi >= 0);
      disp = (ri >= 0) && bus.fu_ready;
      for (int e = 0; e < 3; e++) begin
        if (m_busy[e]) begin
          model_capture(m_qj[e], m_vj[e], m_qj[e], m_vj[e]);
          model_capture(m_qk[e], m_vk[e], m_qk[e], m_vk[e]);
        end
      end
      if (disp) begin
        m_busy[ri] = 0;
        n_disp++;
      end
      if (acc) begin
        m_busy[fi] = 1;
        m_op[fi] = bus.issue_op;
        model_capture(bus.issue_qj, bus.issue_vj, m_qj[fi], m_vj[fi]);
        model_capture(bus.issue_qk, bus.issue_vk, m_qk[fi], m_vk[fi]);
      end
      m_occ = m_occ + (acc ? 1 : 0) - (disp ? 1 : 0);
      tick();
    end
    idle_inputs();
    $display("test_random done dispatches=%0d", n_disp);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_dispatch();
    test_wakeup();
    test_bypass();
    test_full_and_switch();
    test_bus_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
